// File: rtl/aes_pkg.sv
// Shared definitions for the S-box sharing scheduler: FSM encoding, column slicing and
// the AES forward S-box lookup table.
package aes_pkg;

    localparam int unsigned NUM_COLS = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Entry 0 sits in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lut(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
    endfunction

    // Column c occupies bits [127-32c -: 32].
    function automatic logic [31:0] col_word(input logic [127:0] state, input logic [1:0] idx);
        return state[127 - 32 * int'(idx) -: 32];
    endfunction

endpackage

// File: rtl/sbox_word.sv
// 32-bit combinational substitution bank built from four byte S-box lanes.
module sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar b = 0; b < 4; b++) begin : g_lane
        assign word_o[8*b +: 8] = sbox_lut(word_i[8*b +: 8]);
    end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares one 32-bit S-box bank between column-wise SubBytes of a 128-bit state and
// key-expansion SubWord requests, with optional alternating key priority during RUN.
module sbox_share_ctrl
    import aes_pkg::*;
#(
    parameter bit KEY_PRIO = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_in,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out,
    input  logic         kw_req,
    input  logic [31:0]  kw_in,
    output logic         kw_gnt,
    output logic         kw_valid,
    output logic [31:0]  kw_out
);

    logic [1:0]   state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] buf_q, buf_d;
    logic         last_key_q;
    logic         kw_valid_q;
    logic [31:0]  kw_out_q;
    logic [31:0]  bank_in, bank_out;

    always_comb begin
        kw_gnt = kw_req;
        if (state_q == ST_RUN) begin
            kw_gnt = KEY_PRIO ? (kw_req & ~last_key_q) : 1'b0;
        end
    end

    assign bank_in = kw_gnt ? kw_in : col_word(buf_q, col_q);

    sbox_word u_bank (
        .word_i (bank_in),
        .word_o (bank_out)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (st_valid) begin
                    buf_d   = st_in;
                    col_d   = 2'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A key grant stalls the column; otherwise the column is rewritten in place.
                if (!kw_gnt) begin
                    buf_d[127 - 32 * int'(col_q) -: 32] = bank_out;
                    col_d = col_q + 2'd1;
                    if (col_q == 2'(NUM_COLS - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (st_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            col_q      <= 2'd0;
            buf_q      <= '0;
            last_key_q <= 1'b0;
            kw_valid_q <= 1'b0;
            kw_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            buf_q      <= buf_d;
            last_key_q <= kw_gnt;
            kw_valid_q <= kw_gnt;
            if (kw_gnt) begin
                kw_out_q <= bank_out;
            end
        end
    end

    assign st_ready     = (state_q == ST_IDLE);
    assign st_out_valid = (state_q == ST_DONE);
    assign st_out       = buf_q;
    assign kw_valid     = kw_valid_q;
    assign kw_out       = kw_out_q;

endmodule
